// File: rtl/melody_sequencer_pkg.sv
// melody_pkg: note codes, half-period table, song ROM and FSM state encoding for melody_sequencer
package melody_pkg;
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4 = 4'd1;
  localparam logic [3:0] NOTE_D4 = 4'd2;
  localparam logic [3:0] NOTE_E4 = 4'd3;
  localparam logic [3:0] NOTE_F4 = 4'd4;
  localparam logic [3:0] NOTE_G4 = 4'd5;
  localparam logic [3:0] NOTE_A4 = 4'd6;
  localparam logic [3:0] NOTE_B4 = 4'd7;
  localparam logic [3:0] NOTE_C5 = 4'd8;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BEAT = 2'd1, PLAY = 2'd2} state_t;
  localparam logic [3:0] SONG [16] = '{
    NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4, NOTE_C5,
    NOTE_C5, NOTE_B4, NOTE_A4, NOTE_G4, NOTE_F4, NOTE_E4, NOTE_D4, NOTE_C4
  };
  // Half-period in 50 MHz clocks, round(50e6 / (2 * f)); 0 marks a rest.
  function automatic logic [17:0] half_period(input logic [3:0] code);
    case (code)
      NOTE_C4: return 18'd95556;
      NOTE_D4: return 18'd85131;
      NOTE_E4: return 18'd75843;
      NOTE_F4: return 18'd71586;
      NOTE_G4: return 18'd63776;
      NOTE_A4: return 18'd56818;
      NOTE_B4: return 18'd50619;
      NOTE_C5: return 18'd47778;
      default: return 18'd0;
    endcase
  endfunction
endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// tone_gen: square wave toggling every `half` clocks; half=0 is a rest (held low)
//   clock, reset : system clock, async active-high reset
//   half         : half-period in clocks of the current note
//   restart      : note is changing this edge; clear phase so the note starts low
//   speaker      : square-wave output
module tone_gen #(
  parameter int TONE_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TONE_W-1:0] half,
  input  logic              restart,
  output logic              speaker
);
  logic [TONE_W-1:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count <= '0;
      speaker <= 1'b0;
    end else if (restart || half == '0) begin
      count <= '0;
      speaker <= 1'b0;
    end else if (count == half - 1'b1) begin
      count <= '0;
      speaker <= ~speaker;
    end else
      count <= count + 1'b1;
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays the song ROM one note per beat_in edge through a square-wave speaker
//   clock, reset : 50 MHz clock, async active-high reset
//   beat_in      : slow toggle, every edge is one beat (synchronized here)
//   play, stop   : start request (ignored while busy), abort request (wins over everything)
//   speaker      : audio output; note_code: sounding note (0 = rest/idle)
//   busy         : playing; done: one-cycle pulse when the last note's beat ends
//   MELODY_LOOP_EN defined: song repeats forever, done pulses on every wrap
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int TONE_W   = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       beat_in,
  input  logic       play,
  input  logic       stop,
  output logic       speaker,
  output logic [3:0] note_code,
  output logic       busy,
  output logic       done
);
`ifdef MELODY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int IW = SONG_LEN > 1 ? $clog2(SONG_LEN) : 1;
  logic s1, s2, s3, beat_tick;
  state_t state;
  logic [IW-1:0] index, index_nxt;
  logic last;
  logic [3:0] note_d;
  assign last = index == IW'(SONG_LEN - 1);
  assign index_nxt = last ? '0 : index + 1'b1;
  // Next note is computed ahead of the register so the tone generator can
  // realign its phase on the very edge the note changes.
  assign note_d = stop ? NOTE_REST
    : !beat_tick ? note_code
    : state == WAIT_BEAT ? SONG[0]
    : state != PLAY ? note_code
    : last && !LOOP ? NOTE_REST
    : SONG[4'(index_nxt)];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      beat_tick <= 1'b0;
    end else begin
      s1 <= beat_in;
      s2 <= s1;
      s3 <= s2;
      beat_tick <= s2 ^ s3;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      index <= '0;
      note_code <= NOTE_REST;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      note_code <= note_d;
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        index <= '0;
        busy <= 1'b0;
      end else
        case (state)
          IDLE: if (play) begin
            state <= WAIT_BEAT;
            index <= '0;
            busy <= 1'b1;
          end
          WAIT_BEAT: if (beat_tick) state <= PLAY;
          PLAY: if (beat_tick) begin
            index <= index_nxt;
            if (last) begin
              done <= 1'b1;
              if (!LOOP) begin
                state <= IDLE;
                busy <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
    end
  tone_gen #(.TONE_W(TONE_W)) u_tone (
    .clock  (clock),
    .reset  (reset),
    .half   (TONE_W'(half_period(note_code))),
    .restart(note_d != note_code),
    .speaker(speaker)
  );
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed, table-driven checks of melody_sequencer
module tb_melody_sequencer;
  logic clock = 1'b0, reset = 1'b1, beat_in = 1'b0, play = 1'b0, stop = 1'b0;
  logic speaker, busy, done;
  logic [3:0] note_code;
  int n_pass = 0, n_total = 0;

  typedef struct {
    int gap;
    logic [3:0] note;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl [17];
  logic [3:0] song_exp [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

  melody_sequencer dut (
    .clock(clock), .reset(reset), .beat_in(beat_in), .play(play), .stop(stop),
    .speaker(speaker), .note_code(note_code), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic beat(input int gap);
    @(negedge clock);
    beat_in = ~beat_in;
    repeat (gap) @(negedge clock);
  endtask

  task automatic do_play();
    @(negedge clock);
    play = 1'b1;
    @(negedge clock);
    play = 1'b0;
  endtask

  task automatic tone_check();
    int k;
    k = 0;
    chk("spk_start_low", speaker, 0);
    while (!speaker && k < 60000) begin
      @(negedge clock);
      k++;
    end
    chk("spk_first_toggle", k, 56818);
  endtask

  initial begin
    logic [3:0] prev;
    bit tone_done;
    int busy_seen, note_seen, dones;
    for (int i = 0; i < 16; i++) tbl[i] = '{1000, song_exp[i], 1'b1, 1'b0};
    tbl[16] = '{0, 4'd0, 1'b0, 1'b1};

    // reset held with beat activity
    repeat (3) begin
      @(negedge clock);
      beat_in = ~beat_in;
      repeat (4) @(negedge clock);
    end
    chk("rst_speaker", speaker, 0);
    chk("rst_note", note_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    busy_seen = 0;
    note_seen = 0;
    repeat (4) begin
      @(negedge clock);
      beat_in = ~beat_in;
      repeat (10) begin
        @(negedge clock);
        busy_seen += int'(busy);
        note_seen += int'(note_code != 0);
      end
    end
    chk("idle_busy_never", busy_seen, 0);
    chk("idle_note_never", note_seen, 0);

    // play and stop together in IDLE: stop wins
    @(negedge clock);
    play = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    play = 1'b0;
    stop = 1'b0;
    chk("play_stop_busy", busy, 0);
    beat(8);
    chk("play_stop_note", note_code, 0);

    // accepted play
    do_play();
    chk("play_busy", busy, 1);
    chk("play_note_wait", note_code, 0);

`ifdef MELODY_LOOP_EN
    dones = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clock);
      beat_in = ~beat_in;
      repeat (8) begin
        @(negedge clock);
        dones += int'(done);
      end
      if (i == 16) chk("loop_wrap_note", note_code, 1);
    end
    chk("loop_dones", dones, 2);
    chk("loop_busy", busy, 1);
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
`else
    prev = 4'd0;
    tone_done = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      beat_in = ~beat_in;
      repeat (3) @(negedge clock);
      chk($sformatf("latency_%0d", i), note_code, prev);
      @(negedge clock);
      chk($sformatf("note_%0d", i), note_code, tbl[i].note);
      chk($sformatf("busy_%0d", i), busy, tbl[i].busy);
      chk($sformatf("done_%0d", i), done, tbl[i].done);
      if (tbl[i].note == 4'd6 && !tone_done) begin
        tone_check();
        tone_done = 1'b1;
      end
      prev = tbl[i].note;
      repeat (tbl[i].gap) @(negedge clock);
    end
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("end_speaker", speaker, 0);
`endif

    // stop during note 4
    repeat (10) @(negedge clock);
    do_play();
    repeat (4) beat(10);
    chk("pre_stop_note", note_code, 4);
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("stop_note", note_code, 0);
    chk("stop_busy", busy, 0);
    chk("stop_speaker", speaker, 0);
    chk("stop_done", done, 0);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      beat_in = ~beat_in;
      repeat (8) begin
        @(negedge clock);
        dones += int'(done) + int'(busy) + int'(note_code != 0);
      end
    end
    chk("stop_stays_idle", dones, 0);

    // reset mid note 3, then replay from the start
    do_play();
    repeat (3) beat(10);
    repeat (20) @(negedge clock);
    chk("pre_reset_note", note_code, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_note", note_code, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_speaker", speaker, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    do_play();
    chk("replay_busy", busy, 1);
    beat(6);
    chk("replay_note", note_code, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
